// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared MAC widths and dot-product sequencer state encoding
package mac_pkg;

    localparam int MAC_A_W   = 16;
    localparam int MAC_ACC_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_e;

endpackage

// File: rtl/mac_dot_seq_if.sv
// rtl/mac_dot_seq_if.sv - command, operand, MAC and result signals of the dot-product sequencer
interface mac_dot_seq_if #(
    parameter int LEN_W = 8
);
    import mac_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [LEN_W-1:0]     cmd_len;
    logic [MAC_ACC_W-1:0] cmd_bias;

    logic                 op_valid;
    logic                 op_ready;
    logic [MAC_A_W-1:0]   op_a;
    logic [MAC_A_W-1:0]   op_b;

    logic [MAC_A_W-1:0]   mac_a;
    logic [MAC_A_W-1:0]   mac_b;
    logic [MAC_ACC_W-1:0] mac_c;
    logic                 mac_valid;
    logic                 mac_ready;
    logic [MAC_ACC_W-1:0] mac_result;

    logic                 res_valid;
    logic                 res_ready;
    logic [MAC_ACC_W-1:0] res_data;
    logic                 err_timeout;

    // Sequencer side
    modport master (
        input  cmd_valid, cmd_len, cmd_bias,
        output cmd_ready,
        input  op_valid, op_a, op_b,
        output op_ready,
        output mac_a, mac_b, mac_c, mac_valid,
        input  mac_ready, mac_result,
        output res_valid, res_data, err_timeout,
        input  res_ready
    );

    // Environment side: command/operand buffers, MAC unit and result consumer
    modport slave (
        output cmd_valid, cmd_len, cmd_bias,
        input  cmd_ready,
        output op_valid, op_a, op_b,
        input  op_ready,
        input  mac_a, mac_b, mac_c, mac_valid,
        output mac_ready, mac_result,
        input  res_valid, res_data, err_timeout,
        output res_ready
    );

endinterface

// File: rtl/mac_dot_seq.sv
// rtl/mac_dot_seq.sv - streams operand pairs through a single-op MAC, chaining results into a dot product
module mac_dot_seq
    import mac_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    mac_dot_seq_if.master bus
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [MAC_ACC_W-1:0] acc_q;
    logic [LEN_W-1:0]     cnt_q;
    logic [TMO_W-1:0]     tmo_q;
    logic [MAC_A_W-1:0]   mac_a_q, mac_b_q;
    logic [MAC_ACC_W-1:0] mac_c_q;
    logic [MAC_ACC_W-1:0] res_data_q;
    logic                 cmd_ready_q, op_ready_q, mac_valid_q, res_valid_q, err_q;
    logic                 tmo_hit;

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));

    // Next-state selection; only one MAC op is ever outstanding
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (bus.cmd_valid) state_d = (bus.cmd_len == '0) ? DONE : FETCH;
            FETCH: if (bus.op_valid) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.mac_ready)   state_d = (cnt_q == LEN_W'(1)) ? DONE : FETCH;
                else if (tmo_hit)    state_d = ERR;
            end
            DONE:  if (bus.res_ready) state_d = IDLE;
            ERR:   if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and handshake outputs; outputs are registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_c_q     <= '0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            op_ready_q  <= 1'b0;
            mac_valid_q <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= (state_d == IDLE);
            op_ready_q  <= (state_d == FETCH);
            mac_valid_q <= (state_d == ISSUE);
            res_valid_q <= (state_d == DONE) || (state_d == ERR);

            unique case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        acc_q <= bus.cmd_bias;
                        cnt_q <= bus.cmd_len;
                        err_q <= 1'b0;
                        // Zero-length command answers with the bias directly
                        if (bus.cmd_len == '0) res_data_q <= bus.cmd_bias;
                    end
                end
                FETCH: begin
                    if (bus.op_valid) begin
                        mac_a_q <= bus.op_a;
                        mac_b_q <= bus.op_b;
                        mac_c_q <= acc_q;
                    end
                end
                ISSUE: tmo_q <= '0;
                WAIT: begin
                    if (bus.mac_ready) begin
                        acc_q <= bus.mac_result;
                        cnt_q <= cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) res_data_q <= bus.mac_result;
                    end else if (tmo_hit) begin
                        // Report the partial sum accumulated so far
                        res_data_q <= acc_q;
                        err_q      <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.op_ready    = op_ready_q;
    assign bus.mac_a       = mac_a_q;
    assign bus.mac_b       = mac_b_q;
    assign bus.mac_c       = mac_c_q;
    assign bus.mac_valid   = mac_valid_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_mac_dot_seq.sv
// tb/tb_mac_dot_seq.sv - directed scoreboard bench for mac_dot_seq with a 1-cycle MAC responder
module tb_mac_dot_seq;
    import mac_pkg::*;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] c;
    } mac_op_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_dot_seq_if #(.LEN_W(8)) bus ();

    mac_dot_seq #(.LEN_W(8), .TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    mac_op_t     exp_op_q[$];
    logic [31:0] exp_res_q[$];
    logic [31:0] exp_acc;
    logic [31:0] partial;
    int cycle = 0;
    int issue_n = 0;
    int drop_at = -1;
    int pulses = 0;
    int last_issue_cycle = 0;
    int p0;
    int n;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural MAC: result one cycle after issue; can withhold the response for one op
    always @(posedge clk) begin
        bus.mac_ready <= 1'b0;
        if (bus.mac_valid === 1'b1) begin
            issue_n <= issue_n + 1;
            if (issue_n + 1 != drop_at) begin
                bus.mac_ready  <= 1'b1;
                bus.mac_result <= {16'b0, bus.mac_a} * {16'b0, bus.mac_b} + bus.mac_c;
            end
        end
    end

    // Issue monitor: every MAC issue must match the next expected operand triple
    always @(negedge clk) begin
        if (rst !== 1'b1 && bus.mac_valid === 1'b1) begin
            pulses           <= pulses + 1;
            last_issue_cycle <= cycle;
            check("mac_issue_expected", 32'(exp_op_q.size() > 0), 32'd1);
            if (exp_op_q.size() > 0) begin
                check("mac_a", {16'b0, bus.mac_a}, {16'b0, exp_op_q[0].a});
                check("mac_b", {16'b0, bus.mac_b}, {16'b0, exp_op_q[0].b});
                check("mac_c", bus.mac_c, exp_op_q[0].c);
                void'(exp_op_q.pop_front());
            end
        end
    end

    task automatic send_cmd(input logic [7:0] len, input logic [31:0] bias);
        int k;
        exp_acc       = bias;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = len;
        bus.cmd_bias  = bias;
        k = 0;
        while (bus.cmd_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("cmd_accept_in_time", 32'(k < 100), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_op(input logic [15:0] a, input logic [15:0] b);
        int k;
        exp_op_q.push_back('{a: a, b: b, c: exp_acc});
        exp_acc    = {16'b0, a} * {16'b0, b} + exp_acc;
        bus.op_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        k = 0;
        while (bus.op_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("op_accept_in_time", 32'(k < 100), 32'd1);
        @(negedge clk);
        bus.op_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (bus.res_valid !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(k < 200), 32'd1);
    endtask

    task automatic take_res(input string name, input logic exp_err);
        logic [31:0] exp;
        wait_valid({name, "_valid"});
        exp = (exp_res_q.size() > 0) ? exp_res_q.pop_front() : 32'hDEAD_BEEF;
        check({name, "_data"}, bus.res_data, exp);
        check({name, "_err"}, {31'b0, bus.err_timeout}, {31'b0, exp_err});
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check({name, "_released"}, {30'b0, bus.res_valid, bus.cmd_ready}, 32'h1);
    endtask

    task automatic check_reset(input string name);
        check({name, "_ctrl"},
              {27'b0, bus.cmd_ready, bus.op_ready, bus.mac_valid, bus.res_valid, bus.err_timeout},
              32'h10);
        check({name, "_mac_ab"}, {bus.mac_a, bus.mac_b}, 32'h0);
        check({name, "_mac_c"}, bus.mac_c, 32'h0);
        check({name, "_res_data"}, bus.res_data, 32'h0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.cmd_bias  = '0;
        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single op: 2*3+4
        p0 = pulses;
        send_cmd(8'd1, 32'd4);
        send_op(16'd2, 16'd3);
        exp_res_q.push_back(exp_acc);
        take_res("len1", 1'b0);
        check("len1_pulses", 32'(pulses - p0), 32'd1);

        // Three chained ops, result held while downstream stalls
        p0 = pulses;
        send_cmd(8'd3, 32'd1);
        send_op(16'd5, 16'd7);
        send_op(16'd2, 16'd2);
        send_op(16'd0, 16'd100);
        wait_valid("len3_valid");
        check("len3_data", bus.res_data, exp_acc);
        // New command and an extra operand presented while the sum is still pending
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'd0;
        bus.cmd_bias  = 32'd77;
        bus.op_valid  = 1'b1;
        bus.op_a      = 16'd9;
        bus.op_b      = 16'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_res_valid", {31'b0, bus.res_valid}, 32'd1);
            check("hold_res_data", bus.res_data, exp_acc);
            check("hold_busy", {30'b0, bus.cmd_ready, bus.op_ready}, 32'd0);
        end
        bus.res_ready = 1'b1;
        bus.op_valid  = 1'b0;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("same_cycle_idle", {30'b0, bus.res_valid, bus.cmd_ready}, 32'h1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("same_cycle_cmd_taken", {31'b0, bus.res_valid}, 32'd1);
        exp_res_q.push_back(32'd77);
        take_res("queued_len0", 1'b0);
        check("len3_pulses", 32'(pulses - p0), 32'd3);

        // Zero-length command: bias returned next cycle, no MAC traffic
        p0 = pulses;
        send_cmd(8'd0, 32'd50);
        check("len0_next_cycle", {31'b0, bus.res_valid}, 32'd1);
        exp_res_q.push_back(32'd50);
        take_res("len0", 1'b0);
        check("len0_pulses", 32'(pulses - p0), 32'd0);

        // Second op never answered: partial sum reported with err_timeout
        drop_at = issue_n + 2;
        send_cmd(8'd2, 32'd3);
        send_op(16'd4, 16'd5);
        partial = exp_acc;
        send_op(16'd6, 16'd7);
        void'(exp_op_q.size());
        wait_valid("tmo_valid");
        check("tmo_latency", 32'(cycle - last_issue_cycle), 32'd65);
        exp_res_q.push_back(partial);
        take_res("tmo", 1'b1);
        check("tmo_err_sticky", {31'b0, bus.err_timeout}, 32'd1);
        drop_at = -1;
        send_cmd(8'd1, 32'd0);
        check("err_cleared_on_cmd", {31'b0, bus.err_timeout}, 32'd0);
        send_op(16'd3, 16'd3);
        exp_res_q.push_back(exp_acc);
        take_res("after_tmo", 1'b0);

        // Reset while waiting on the MAC aborts immediately
        drop_at = issue_n + 1;
        send_cmd(8'd1, 32'd5);
        send_op(16'd1, 16'd1);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset("reset_in_wait");
        @(negedge clk);
        rst     = 1'b0;
        drop_at = -1;
        exp_op_q.delete();
        @(negedge clk);
        send_cmd(8'd2, 32'd7);
        send_op(16'd1, 16'd2);
        send_op(16'd3, 16'd3);
        exp_res_q.push_back(exp_acc);
        take_res("post_reset", 1'b0);
        check("ops_all_issued", 32'(exp_op_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
